// File: rtl/delay_burst_responder_if.sv
// rtl/delay_burst_responder_if.sv - read (AR/R) and write (AW/W/B) channel bundle for the delay responder
interface delay_burst_responder_if;
    logic        ARVALID;
    logic        ARREADY;
    logic [15:0] IN;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [8:0]  OUT;
    logic        AWVALID;
    logic        AWREADY;
    logic [11:0] AWIN;
    logic        WVALID;
    logic        WREADY;
    logic        WLAST;
    logic [7:0]  WDATA;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;

    modport master (
        output ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY,
        input  ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY,
        output ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/delay_burst_responder.sv
// rtl/delay_burst_responder.sv - byte-store responder answering bursts after a programmable delay
module delay_burst_responder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              DELAY,
    delay_burst_responder_if.slave  bus,
    output logic                    RIDLE,
    output logic                    WIDLE,
    output logic                    RIDLE_prev,
    output logic                    WIDLE_prev
);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

    logic [7:0] mem [DEPTH];

    r_state_t   r_state, r_next;
    logic [7:0] r_addr;
    logic [3:0] r_len;
    logic [3:0] r_beat;
    logic [4:0] r_cnt;
    logic       r_in_range;

    w_state_t   w_state, w_next;
    logic [7:0] w_addr;
    logic [3:0] w_id;
    logic [4:0] w_delay;
    logic [4:0] w_cnt;
    logic       w_err;
    logic       w_in_range;

    assign r_in_range = ({1'b0, r_addr} < 9'(DEPTH));
    assign w_in_range = ({1'b0, w_addr} < 9'(DEPTH));
    assign RIDLE      = (r_state == R_IDLE);
    assign WIDLE      = (w_state == W_IDLE);

    // Read beat is combinational from registered state, so it stays put while stalled
    always_comb begin
        r_next      = r_state;
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        bus.RLAST   = 1'b0;
        bus.OUT     = 9'h000;
        case (r_state)
            R_IDLE: begin
                bus.ARREADY = 1'b1;
                if (bus.ARVALID) r_next = (DELAY == 5'd0) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_cnt == 5'd1) r_next = R_DATA;
            end
            R_DATA: begin
                bus.RVALID = 1'b1;
                bus.RLAST  = (r_beat == r_len);
                bus.OUT    = {r_in_range ? mem[r_addr[ADDR_W-1:0]] : 8'h00, ~r_in_range};
                if (bus.RREADY && bus.RLAST) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            r_addr     <= 8'h00;
            r_len      <= 4'h0;
            r_beat     <= 4'h0;
            r_cnt      <= 5'd0;
            RIDLE_prev <= 1'b1;
        end else begin
            r_state    <= r_next;
            RIDLE_prev <= RIDLE;
            case (r_state)
                R_IDLE: if (bus.ARVALID) begin
                    r_addr <= bus.IN[11:4];
                    r_len  <= bus.IN[3:0];
                    r_beat <= 4'h0;
                    r_cnt  <= DELAY;
                end
                R_WAIT: r_cnt <= r_cnt - 5'd1;
                R_DATA: if (bus.RREADY) begin
                    r_addr <= r_addr + 8'd1;
                    r_beat <= r_beat + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = w_state;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BVALID  = 1'b0;
        bus.BRESP   = 5'h00;
        case (w_state)
            W_IDLE: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                bus.WREADY = 1'b1;
                if (bus.WVALID && bus.WLAST) w_next = (w_delay == 5'd0) ? W_RESP : W_WAIT;
            end
            W_WAIT: begin
                if (w_cnt == 5'd1) w_next = W_RESP;
            end
            W_RESP: begin
                bus.BVALID = 1'b1;
                bus.BRESP  = {w_id, w_err};
                if (bus.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Storage lives with the write side; reads sample it before this edge's write lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            w_addr     <= 8'h00;
            w_id       <= 4'h0;
            w_delay    <= 5'd0;
            w_cnt      <= 5'd0;
            w_err      <= 1'b0;
            WIDLE_prev <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            w_state    <= w_next;
            WIDLE_prev <= WIDLE;
            case (w_state)
                W_IDLE: if (bus.AWVALID) begin
                    w_id    <= bus.AWIN[11:8];
                    w_addr  <= bus.AWIN[7:0];
                    w_delay <= DELAY;
                    w_err   <= 1'b0;
                end
                W_DATA: if (bus.WVALID) begin
                    if (w_in_range) mem[w_addr[ADDR_W-1:0]] <= bus.WDATA;
                    else            w_err <= 1'b1;
                    w_addr <= w_addr + 8'd1;
                    w_cnt  <= w_delay;
                end
                W_WAIT: w_cnt <= w_cnt - 5'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_delay_burst_responder.sv
// tb/tb_delay_burst_responder.sv - randomized scoreboard bench for delay_burst_responder
module tb_delay_burst_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] DELAY = 5'd0;
    logic       RIDLE, WIDLE, RIDLE_prev, WIDLE_prev;
    logic       rr_q = 1'b1;
    bit         rr_rand = 1'b0;

    delay_burst_responder_if bus();

    delay_burst_responder #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .DELAY      (DELAY),
        .bus        (bus),
        .RIDLE      (RIDLE),
        .WIDLE      (WIDLE),
        .RIDLE_prev (RIDLE_prev),
        .WIDLE_prev (WIDLE_prev)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.RREADY = rr_q;
    assign bus.BREADY = 1'b1;

    always @(posedge clk) begin
        #1;
        rr_q = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [16];
    logic [9:0] r_exp_q [$];
    int         r_lat_q [$];
    logic [4:0] b_exp_q [$];
    int         b_lat_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input logic [4:0] d, input int nb);
        logic       err;
        logic [7:0] a;
        logic [7:0] dat;
        err = 1'b0;
        a   = addr;
        @(negedge clk);
        bus.AWVALID = 1'b1;
        bus.AWIN    = {id, addr};
        DELAY       = d;
        for (int i = 0; i < 300 && !bus.AWREADY; i++) @(negedge clk);
        if (!bus.AWREADY) chk("aw_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.AWVALID = 1'b0;
        DELAY       = 5'($urandom);
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            dat         = (b == 0 && id == 4'h4 && addr == 8'h03) ? 8'hA1 :
                          (b == 1 && id == 4'h4 && addr == 8'h03) ? 8'hB2 : 8'($urandom);
            bus.WVALID  = 1'b1;
            bus.WDATA   = dat;
            bus.WLAST   = (b == nb - 1);
            for (int i = 0; i < 300 && !bus.WREADY; i++) @(negedge clk);
            if (!bus.WREADY) chk("w_timeout", 0, 1);
            @(posedge clk);
            #1;
            if (a < 8'd16) ref_mem[a[3:0]] = dat;
            else           err = 1'b1;
            a = a + 8'd1;
            if (b == nb - 1) begin
                b_exp_q.push_back({id, err});
                b_lat_q.push_back((cyc - 1) + int'(d) + 1);
            end
            bus.WVALID = 1'b0;
            bus.WLAST  = 1'b0;
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [3:0] len, input logic [4:0] d);
        logic [7:0] a;
        @(negedge clk);
        bus.ARVALID = 1'b1;
        bus.IN      = {id, addr, len};
        DELAY       = d;
        for (int i = 0; i < 300 && !bus.ARREADY; i++) @(negedge clk);
        if (!bus.ARREADY) chk("ar_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.ARVALID = 1'b0;
        DELAY       = 5'($urandom);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            r_exp_q.push_back({(i == int'(len)), (a < 8'd16) ? ref_mem[a[3:0]] : 8'h00, (a >= 8'd16)});
            a = a + 8'd1;
        end
        r_lat_q.push_back((cyc - 1) + int'(d) + 1);
        chk("ridle_fall", {RIDLE, RIDLE_prev}, 2'b01);
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 800; i++) begin
            @(negedge clk);
            if (RIDLE && WIDLE && r_exp_q.size() == 0 && b_exp_q.size() == 0) break;
        end
        if (i == 800) chk("idle_timeout", 0, 1);
    endtask

    // Read channel monitor: latency of first beat, beat contents, stability under stall
    bit         in_burst = 1'b0;
    bit         stall_pend = 1'b0;
    logic [8:0] held_out;
    logic       held_last;
    always @(negedge clk) begin
        if (!rst) begin
            in_burst   = 1'b0;
            stall_pend = 1'b0;
        end else begin
            if (stall_pend)
                chk("r_stable", {bus.RVALID, bus.RLAST, bus.OUT}, {1'b1, held_last, held_out});
            if (bus.RVALID && !in_burst) begin
                in_burst = 1'b1;
                if (r_lat_q.size() == 0) chk("r_unexpected", 1, 0);
                else                     chk("r_latency", cyc, r_lat_q.pop_front());
            end
            if (bus.RVALID && bus.RREADY) begin
                if (r_exp_q.size() == 0) chk("r_unexpected_beat", 1, 0);
                else                     chk("r_beat", {bus.RLAST, bus.OUT}, r_exp_q.pop_front());
                chk("r_ridle_busy", RIDLE, 0);
                if (bus.RLAST) in_burst = 1'b0;
            end
            stall_pend = bus.RVALID && !bus.RREADY;
            held_out   = bus.OUT;
            held_last  = bus.RLAST;
        end
    end

    always @(negedge clk) begin
        if (rst && bus.BVALID && bus.BREADY) begin
            if (b_exp_q.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                chk("bresp", bus.BRESP, b_exp_q.pop_front());
                chk("b_latency", cyc, b_lat_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        bus.ARVALID = 1'b0;
        bus.IN      = 16'h0000;
        bus.AWVALID = 1'b0;
        bus.AWIN    = 12'h000;
        bus.WVALID  = 1'b0;
        bus.WLAST   = 1'b0;
        bus.WDATA   = 8'h00;
        clear_model();

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready",  {bus.ARREADY, bus.AWREADY}, 2'b11);
        chk("rst_valid",  {bus.RVALID, bus.BVALID, bus.RLAST, bus.WREADY}, 4'b0000);
        chk("rst_out",    bus.OUT, 9'h000);
        chk("rst_bresp",  bus.BRESP, 5'h00);
        chk("rst_idle",   {RIDLE, WIDLE, RIDLE_prev, WIDLE_prev}, 4'b1111);

        do_write(4'h4, 8'h03, 5'd10, 2);
        wait_idle();
        chk("model_a1", ref_mem[3], 8'hA1);
        do_read(4'h5, 8'h03, 4'h1, 5'd20);
        wait_idle();

        do_write(4'h2, 8'h0F, 5'd0, 1);
        wait_idle();
        do_read(4'h1, 8'h0F, 4'h1, 5'd0);
        wait_idle();
        do_write(4'h7, 8'h20, 5'd1, 1);
        wait_idle();
        do_write(4'h3, 8'hFF, 5'd2, 3);
        wait_idle();

        rr_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 0)
                do_write(4'($urandom), a, 5'($urandom_range(0, 31)), $urandom_range(1, 4));
            else
                do_read(4'($urandom), a, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            wait_idle();
        end
        rr_rand = 1'b0;
        @(posedge clk);

        // Concurrent read and write hitting addr 3 on the same edge, then reset during write wait
        @(negedge clk);
        bus.ARVALID = 1'b1;
        bus.IN      = {4'h5, 8'h03, 4'h0};
        bus.AWVALID = 1'b1;
        bus.AWIN    = {4'h4, 8'h03};
        DELAY       = 5'd3;
        @(posedge clk);
        #1;
        bus.ARVALID = 1'b0;
        bus.AWVALID = 1'b0;
        r_exp_q.push_back({1'b1, ref_mem[3], 1'b0});
        r_lat_q.push_back((cyc - 1) + 3 + 1);
        repeat (3) @(posedge clk);
        #1;
        bus.WVALID = 1'b1;
        bus.WDATA  = ~ref_mem[3];
        bus.WLAST  = 1'b1;
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_wait_busy", WIDLE, 0);
        rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_idle", {WIDLE, WIDLE_prev, RIDLE, RIDLE_prev}, 4'b1111);
        chk("abort_no_b", bus.BVALID, 0);
        repeat (20) @(negedge clk);
        do_read(4'h6, 8'h03, 4'h0, 5'd1);
        wait_idle();

        chk("r_q_drained", r_exp_q.size(), 0);
        chk("b_q_drained", b_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
